// File: rtl/operand_entry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : operand_entry_sequencer
//  Purpose  : Keypad-driven controller that sequences entry of two signed
//             decimal operands, launches the Booth multiplier and selects the
//             product for display.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1  system clock, rising edge
//    rst          in   1  asynchronous reset, active low
//    key_pressed  in   1  debounced key-held level
//    key_value    in   4  held key: 0-9 digit, A next, B sign, C clear, D equals
//    mult_done    in   1  multiplier product-valid pulse
//    enable_A     out  1  operand A being entered
//    enable_B     out  1  operand B being entered
//    digit_we     out  1  pulse: storage accumulates digit_val
//    digit_val    out  4  digit accompanying digit_we (held otherwise)
//    clear_entry  out  1  pulse: storage clears A, B and temporary value
//    neg_A        out  1  sign of operand A
//    neg_B        out  1  sign of operand B
//    mult_start   out  1  pulse: start the multiplier
//    busy         out  1  multiplication in progress (START/WAIT)
//    show_result  out  1  product selected on the display
//    error        out  1  multiplier did not answer in time
//    digit_count  out  2  digits accepted for the current operand
// ============================================================================
module operand_entry_sequencer #(
   parameter int unsigned MAX_DIGITS   = 3,
   parameter int unsigned DONE_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_pressed,
   input  logic [3:0] key_value,
   input  logic       mult_done,
   output logic       enable_A,
   output logic       enable_B,
   output logic       digit_we,
   output logic [3:0] digit_val,
   output logic       clear_entry,
   output logic       neg_A,
   output logic       neg_B,
   output logic       mult_start,
   output logic       busy,
   output logic       show_result,
   output logic       error,
   output logic [1:0] digit_count
);

   localparam int unsigned   C_TW             = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam logic [C_TW-1:0] C_TIMEOUT_LAST = C_TW'(DONE_TIMEOUT - 1);
   localparam logic [1:0]    C_MAX_DIGITS     = 2'(MAX_DIGITS);
   localparam logic [3:0]    C_KEY_NEXT       = 4'hA;
   localparam logic [3:0]    C_KEY_SIGN       = 4'hB;
   localparam logic [3:0]    C_KEY_CLEAR      = 4'hC;
   localparam logic [3:0]    C_KEY_EQUALS     = 4'hD;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ENTER_A = 3'd1,
      S_ENTER_B = 3'd2,
      S_START   = 3'd3,
      S_WAIT    = 3'd4,
      S_SHOW    = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   state_t          r_state;
   logic            r_prev;
   logic            r_digit_we;
   logic [3:0]      r_digit_val;
   logic            r_clear;
   logic            r_neg_a;
   logic            r_neg_b;
   logic            r_mult_start;
   logic [1:0]      r_count;
   logic [C_TW-1:0] r_timer;

   logic w_event;
   logic w_is_digit;
   logic w_clear_ev;
   logic w_digit_ok;

   // A key event is the rising edge of the held level; holding never repeats.
   assign w_event    = key_pressed & ~r_prev;
   assign w_is_digit = (key_value <= 4'd9);
   assign w_clear_ev = w_event & (key_value == C_KEY_CLEAR);
   assign w_digit_ok = w_event & w_is_digit & (r_count < C_MAX_DIGITS);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_prev       <= 1'b0;
         r_digit_we   <= 1'b0;
         r_digit_val  <= 4'd0;
         r_clear      <= 1'b0;
         r_neg_a      <= 1'b0;
         r_neg_b      <= 1'b0;
         r_mult_start <= 1'b0;
         r_count      <= 2'd0;
         r_timer      <= '0;
      end else begin
         r_prev       <= key_pressed;
         r_digit_we   <= 1'b0;
         r_clear      <= 1'b0;
         r_mult_start <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_event && w_is_digit) begin
                  r_state     <= S_ENTER_A;
                  r_digit_we  <= 1'b1;
                  r_digit_val <= key_value;
                  r_count     <= 2'd1;
               end else if (w_clear_ev) begin
                  r_clear <= 1'b1;
               end
            end

            S_ENTER_A, S_ENTER_B: begin
               if (w_clear_ev) begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
                  r_neg_a <= 1'b0;
                  r_neg_b <= 1'b0;
                  r_count <= 2'd0;
               end else if (w_digit_ok) begin
                  r_digit_we  <= 1'b1;
                  r_digit_val <= key_value;
                  r_count     <= r_count + 2'd1;
               end else if (w_event && key_value == C_KEY_SIGN) begin
                  if (r_state == S_ENTER_A) r_neg_a <= ~r_neg_a;
                  else                      r_neg_b <= ~r_neg_b;
               end else if (w_event && r_count != 2'd0 && r_state == S_ENTER_A
                            && key_value == C_KEY_NEXT) begin
                  r_state <= S_ENTER_B;
                  r_count <= 2'd0;
               end else if (w_event && r_count != 2'd0 && r_state == S_ENTER_B
                            && key_value == C_KEY_EQUALS) begin
                  // mult_start is raised on entry so it is high during START;
                  // the timer counts cycles elapsed since that pulse.
                  r_state      <= S_START;
                  r_mult_start <= 1'b1;
                  r_timer      <= '0;
               end
            end

            S_START: begin
               r_state <= S_WAIT;
               r_timer <= r_timer + C_TW'(1);
            end

            S_WAIT: begin
               // Priority: clear aborts, then a product beats a timeout.
               if (w_clear_ev) begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
                  r_neg_a <= 1'b0;
                  r_neg_b <= 1'b0;
                  r_count <= 2'd0;
               end else if (mult_done) begin
                  r_state <= S_SHOW;
               end else if (r_timer == C_TIMEOUT_LAST) begin
                  r_state <= S_ERROR;
               end else begin
                  r_timer <= r_timer + C_TW'(1);
               end
            end

            S_SHOW: begin
               // Any key dismisses the result; the key itself is consumed.
               if (w_event) begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
                  r_neg_a <= 1'b0;
                  r_neg_b <= 1'b0;
                  r_count <= 2'd0;
               end
            end

            S_ERROR: begin
               if (w_clear_ev) begin
                  r_state <= S_IDLE;
                  r_clear <= 1'b1;
                  r_neg_a <= 1'b0;
                  r_neg_b <= 1'b0;
                  r_count <= 2'd0;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign enable_A    = (r_state == S_ENTER_A);
   assign enable_B    = (r_state == S_ENTER_B);
   assign busy        = (r_state == S_START) || (r_state == S_WAIT);
   assign show_result = (r_state == S_SHOW);
   assign error       = (r_state == S_ERROR);
   assign digit_we    = r_digit_we;
   assign digit_val   = r_digit_val;
   assign clear_entry = r_clear;
   assign neg_A       = r_neg_a;
   assign neg_B       = r_neg_b;
   assign mult_start  = r_mult_start;
   assign digit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_operand_entry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_entry_sequencer
//  Purpose  : Self-checking bench for operand_entry_sequencer. Directed
//             scenarios followed by random key/done traffic, all outputs
//             compared every cycle against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_entry_sequencer;

   localparam int MAXD = 3;
   localparam int TO   = 64;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_pressed;
   logic [3:0] key_value;
   logic       mult_done;
   logic       enable_A, enable_B, digit_we, clear_entry, neg_A, neg_B;
   logic       mult_start, busy, show_result, error;
   logic [3:0] digit_val;
   logic [1:0] digit_count;

   always #5 clk = ~clk;

   operand_entry_sequencer #(.MAX_DIGITS(MAXD), .DONE_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .key_pressed(key_pressed), .key_value(key_value),
      .mult_done(mult_done), .enable_A(enable_A), .enable_B(enable_B),
      .digit_we(digit_we), .digit_val(digit_val), .clear_entry(clear_entry),
      .neg_A(neg_A), .neg_B(neg_B), .mult_start(mult_start), .busy(busy),
      .show_result(show_result), .error(error), .digit_count(digit_count)
   );

   int checks   = 0;
   int failures = 0;

   // ---------------- reference model -----------------
   localparam int P_IDLE = 0, P_A = 1, P_B = 2, P_START = 3, P_WAIT = 4, P_SHOW = 5, P_ERR = 6;
   int         m_phase;
   bit         m_prev;
   int         qa[$];
   int         qb[$];
   bit         m_neg_a, m_neg_b;
   int         m_since;
   bit         e_we, e_clr, e_start;
   logic [3:0] e_val;

   function automatic void model_reset();
      m_phase = P_IDLE; m_prev = 1'b0; qa.delete(); qb.delete();
      m_neg_a = 1'b0; m_neg_b = 1'b0; m_since = 0;
      e_we = 1'b0; e_clr = 1'b0; e_start = 1'b0; e_val = 4'd0;
   endfunction

   function automatic void model_abort();
      m_phase = P_IDLE; e_clr = 1'b1; m_neg_a = 1'b0; m_neg_b = 1'b0;
      qa.delete(); qb.delete();
   endfunction

   function automatic void model_step(bit kp, logic [3:0] kv, bit md);
      bit ev;
      if (!rst) begin model_reset(); return; end
      ev = kp && !m_prev;
      m_prev = kp;
      e_we = 1'b0; e_clr = 1'b0; e_start = 1'b0;
      if (m_phase == P_START) begin
         m_phase = P_WAIT; m_since++;
         return;
      end
      if (ev && kv == 4'hC && m_phase != P_IDLE) begin
         model_abort();
         return;
      end
      case (m_phase)
         P_IDLE: begin
            if (ev && kv <= 4'd9) begin
               m_phase = P_A; qa.push_back(int'(kv)); e_we = 1'b1; e_val = kv;
            end else if (ev && kv == 4'hC) e_clr = 1'b1;
         end
         P_A: if (ev) begin
            if (kv <= 4'd9) begin
               if (qa.size() < MAXD) begin qa.push_back(int'(kv)); e_we = 1'b1; e_val = kv; end
            end else if (kv == 4'hB) m_neg_a = !m_neg_a;
            else if (kv == 4'hA && qa.size() > 0) m_phase = P_B;
         end
         P_B: if (ev) begin
            if (kv <= 4'd9) begin
               if (qb.size() < MAXD) begin qb.push_back(int'(kv)); e_we = 1'b1; e_val = kv; end
            end else if (kv == 4'hB) m_neg_b = !m_neg_b;
            else if (kv == 4'hD && qb.size() > 0) begin
               m_phase = P_START; e_start = 1'b1; m_since = 0;
            end
         end
         P_WAIT: begin
            if (md) m_phase = P_SHOW;
            else begin
               m_since++;
               if (m_since == TO) m_phase = P_ERR;
            end
         end
         P_SHOW: if (ev) model_abort();
         default: ;
      endcase
   endfunction

   function automatic int exp_count();
      if (m_phase == P_IDLE) return 0;
      if (m_phase == P_A)    return qa.size();
      return qb.size();
   endfunction

   // ---------------- checking -----------------
   int n_we, n_start, n_busy, n_clr, cyc_no, start_cyc, err_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      cyc_no++;
      chk("enable_A",    32'(enable_A),    32'(m_phase == P_A));
      chk("enable_B",    32'(enable_B),    32'(m_phase == P_B));
      chk("busy",        32'(busy),        32'(m_phase == P_START || m_phase == P_WAIT));
      chk("show_result", 32'(show_result), 32'(m_phase == P_SHOW));
      chk("error",       32'(error),       32'(m_phase == P_ERR));
      chk("digit_we",    32'(digit_we),    32'(e_we));
      chk("digit_val",   32'(digit_val),   32'(e_val));
      chk("clear_entry", 32'(clear_entry), 32'(e_clr));
      chk("mult_start",  32'(mult_start),  32'(e_start));
      chk("neg_A",       32'(neg_A),       32'(m_neg_a));
      chk("neg_B",       32'(neg_B),       32'(m_neg_b));
      chk("digit_count", 32'(digit_count), 32'(exp_count()));
      if (digit_we)    n_we++;
      if (mult_start)  begin n_start++; start_cyc = cyc_no; end
      if (busy)        n_busy++;
      if (clear_entry) n_clr++;
      if (error && err_cyc < 0) err_cyc = cyc_no;
   endtask

   task automatic cyc(input bit kp, input logic [3:0] kv, input bit md);
      key_pressed = kp; key_value = kv; mult_done = md;
      @(posedge clk);
      model_step(kp, kv, md);
      @(negedge clk);
      compare_all();
   endtask

   task automatic tap(input logic [3:0] kv);
      cyc(1'b1, kv, 1'b0);
      cyc(1'b0, kv, 1'b0);
   endtask

   // ---------------- stimulus -----------------
   initial begin
      bit         kp;
      logic [3:0] kv;
      cyc_no = 0; err_cyc = -1; start_cyc = 0;
      rst = 1'b0; key_pressed = 1'b0; key_value = 4'd0; mult_done = 1'b0;
      model_reset();
      #2 compare_all();
      repeat (2) cyc(1'b0, 4'd0, 1'b0);
      rst = 1'b1;
      repeat (2) cyc(1'b0, 4'd0, 1'b0);

      // Scenario 1: 1,2,A,3,D with mult_done 5 cycles after mult_start
      n_we = 0; n_start = 0; n_busy = 0;
      tap(4'h1); tap(4'h2); tap(4'hA); tap(4'h3); tap(4'hD);
      repeat (4) cyc(1'b0, 4'd0, 1'b0);
      cyc(1'b0, 4'd0, 1'b1);
      repeat (3) cyc(1'b0, 4'd0, 1'b0);
      chk("s1_we_count",    n_we,    3);
      chk("s1_start_count", n_start, 1);
      chk("s1_busy_cycles", n_busy,  6);
      chk("s1_show",        32'(show_result), 1);
      tap(4'hC);

      // Scenario 2: digit overflow
      n_we = 0;
      tap(4'h9); tap(4'h9); tap(4'h9); tap(4'h9);
      chk("s2_we_count",    n_we, 3);
      chk("s2_digit_count", 32'(digit_count), 3);
      tap(4'hC);

      // Scenario 3: A/D with zero digits in ENTER_B, then sign and digit
      tap(4'h4); tap(4'hA); tap(4'hA); tap(4'hD);
      chk("s3_still_B", 32'(enable_B), 1);
      tap(4'hB); tap(4'h5);
      chk("s3_neg_B",     32'(neg_B), 1);
      chk("s3_digit_val", 32'(digit_val), 5);

      // Scenario 4: timeout
      err_cyc = -1;
      tap(4'hD);
      repeat (TO + 4) cyc(1'b0, 4'd0, 1'b0);
      chk("s4_timeout_cycles", 32'(err_cyc - start_cyc), TO);
      tap(4'h5);
      chk("s4_error_holds", 32'(error), 1);
      n_clr = 0;
      tap(4'hC);
      chk("s4_clear_pulses", n_clr, 1);

      // Scenario 5: clear and mult_done together; long key hold
      tap(4'h1); tap(4'hA); tap(4'h2); tap(4'hD);
      repeat (3) cyc(1'b0, 4'd0, 1'b0);
      cyc(1'b1, 4'hC, 1'b1);
      cyc(1'b0, 4'hC, 1'b0);
      chk("s5_no_show", 32'(show_result), 0);
      n_we = 0;
      repeat (20) cyc(1'b1, 4'h3, 1'b0);
      cyc(1'b0, 4'h3, 1'b0);
      chk("s5_single_event", n_we, 1);
      tap(4'hC);

      // Scenario 6: asynchronous reset while waiting
      tap(4'h2); tap(4'hA); tap(4'h3); tap(4'hD);
      repeat (5) cyc(1'b0, 4'd0, 1'b0);
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      cyc(1'b0, 4'd0, 1'b0);
      rst = 1'b1;
      cyc(1'b0, 4'd0, 1'b0);
      tap(4'h7);
      chk("s6_enable_A",  32'(enable_A), 1);
      chk("s6_digit_val", 32'(digit_val), 7);
      chk("s6_count",     32'(digit_count), 1);

      // Random traffic
      kp = 1'b0; kv = 4'd0;
      for (int i = 0; i < 3000; i++) begin
         if (kp) begin
            if ($urandom_range(0, 2) == 0) kp = 1'b0;
         end else if ($urandom_range(0, 3) == 0) begin
            kp = 1'b1;
            if ($urandom_range(0, 1) == 0) kv = 4'($urandom_range(0, 9));
            else                           kv = 4'($urandom_range(10, 15));
         end
         cyc(kp, kv, ($urandom_range(0, 15) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
